// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD event counter.
// Optional feature macro: COUNT_DOWN_EN (enables the down-count/borrow path).
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Any non-decimal nibble is pulled down to 9 so digits stay legal.
  function automatic digit_t clamp(input digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// Control and data bundle between the BCD counter and its environment.
// master drives tick/enable/direction/load, slave (the counter) returns count and wrap.
interface bcd_counter_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                      tick_in;
  logic                      en;
  logic                      dir;
  logic                      load;
  logic [DIGIT_W*DIGITS-1:0] load_val;
  logic [DIGIT_W*DIGITS-1:0] count;
  logic                      wrap;

  modport master (
    output tick_in, en, dir, load, load_val,
    input  count, wrap
  );

  modport slave (
    input  tick_in, en, dir, load, load_val,
    output count, wrap
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade with load, step-in and combinational carry/borrow out.
// Optional feature macro: COUNT_DOWN_EN (adds the borrow path; otherwise dir is ignored).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en_in,
  input  logic   dir,
  input  logic   load,
  input  digit_t load_digit,
  output digit_t digit,
  output logic   carry_out
);

  digit_t next_val;
  logic   terminal;

`ifdef COUNT_DOWN_EN
  logic down;

  assign down = (dir == DIR_DOWN);

  // Out-of-range values (unreachable in practice) fold back into 0..9 either way.
  always_comb begin
    next_val = '0;
    terminal = 1'b0;
    if (down) begin
      terminal = (digit == '0);
      next_val = (digit == '0 || digit > BCD_MAX) ? BCD_MAX : digit - 1'b1;
    end else begin
      terminal = (digit >= BCD_MAX);
      next_val = (digit >= BCD_MAX) ? '0 : digit + 1'b1;
    end
  end
`else
  logic dir_unused;

  assign dir_unused = dir;

  always_comb begin
    terminal = (digit >= BCD_MAX);
    next_val = (digit >= BCD_MAX) ? '0 : digit + 1'b1;
  end
`endif

  assign carry_out = en_in & terminal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= clamp(load_digit);
    end else if (en_in) begin
      digit <= next_val;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-decade BCD event counter stepped by rising edges of a slow tick sampled as data.
// Optional feature macro: COUNT_DOWN_EN (honours dir for down counting; default build counts up only).
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic          clk,
  input logic          rst,
  bcd_counter_if.slave bus
);

  logic                      sync1;
  logic                      sync2;
  logic                      prev;
  logic                      step;
  logic [DIGITS:0]           chain;
  logic [DIGIT_W*DIGITS-1:0] count_w;
  logic                      wrap_r;

  // prev tracks sync2 unconditionally so a disabled period never leaves a stale edge behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.tick_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign step     = sync2 & ~prev;
  assign chain[0] = bus.en & step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .en_in      (chain[i]),
      .dir        (bus.dir),
      .load       (bus.load),
      .load_digit (bus.load_val[DIGIT_W*i +: DIGIT_W]),
      .digit      (count_w[DIGIT_W*i +: DIGIT_W]),
      .carry_out  (chain[i+1])
    );
  end

  // The top carry is already qualified by every lower carry and the step, so it marks a full wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= ~bus.load & chain[DIGITS];
    end
  end

  assign bus.count = count_w;
  assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: decimal reference model, per-cycle compare, directed and random ticks.
// Optional feature macro: COUNT_DOWN_EN (adds the down-count scenario and down-wrap modelling).
module tb_bcd_counter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MOD    = 10000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bcd_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int wraps_seen = 0;
  bit armed      = 1'b0;

  int model_val  = 0;
  bit model_wrap = 1'b0;
  bit s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_clamped(input logic [W-1:0] b);
    int v, scale, d;
    v = 0;
    scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  // Reference: an edge counts when the tick sample two edges back is high and the one before it low.
  always @(posedge clk or negedge rst) begin
    bit rise, down;
    if (!rst) begin
      model_val  = 0;
      model_wrap = 1'b0;
      s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    end else begin
      rise = s2 && !s3;
`ifdef COUNT_DOWN_EN
      down = bus.dir;
`else
      down = 1'b0;
`endif
      model_wrap = 1'b0;
      if (bus.load) begin
        model_val = from_bcd_clamped(bus.load_val);
      end else if (bus.en && rise) begin
        if (down) begin
          if (model_val == 0) begin model_val = MOD - 1; model_wrap = 1'b1; end
          else model_val = model_val - 1;
        end else begin
          if (model_val == MOD - 1) begin model_val = 0; model_wrap = 1'b1; end
          else model_val = model_val + 1;
        end
      end
      s3 = s2; s2 = s1; s1 = bus.tick_in;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      if (bus.count !== to_bcd(model_val) || bus.wrap !== model_wrap) begin
        miscompares++;
        $display("[TB] FAIL cycle_compare t=%0t: count=%h wrap=%b, expected count=%h wrap=%b",
                 $time, bus.count, bus.wrap, to_bcd(model_val), model_wrap);
      end
      if (bus.wrap === 1'b1) wraps_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic t, input logic e, input logic d,
                               input logic l, input logic [W-1:0] lv);
    bus.tick_in  = t;
    bus.en       = e;
    bus.dir      = d;
    bus.load     = l;
    bus.load_val = lv;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp_count, input logic exp_wrap);
    @(negedge clk);
    #1;
    vectors++;
    if (bus.count !== exp_count || bus.wrap !== exp_wrap) begin
      miscompares++;
      $display("[TB] FAIL %s: count=%h wrap=%b, expected count=%h wrap=%b",
               name, bus.count, bus.wrap, exp_count, exp_wrap);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tickPulse(input int hi, input int lo);
    bus.tick_in = 1'b1;
    cycles(hi);
    bus.tick_in = 1'b0;
    cycles(lo);
  endtask

  task automatic loadValue(input logic [W-1:0] v);
    bus.load_val = v;
    bus.load     = 1'b1;
    cycles(1);
    bus.load     = 1'b0;
  endtask

  initial begin
    int w0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    cycles(3);
    armed = 1'b1;
    checkOutput("reset_state", 16'h0000, 1'b0);
    rst = 1'b1;
    cycles(2);

    $display("[TB] up count with latency check");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("latency_edge0", 16'h0000, 1'b0);
    cycles(1);
    checkOutput("latency_edge1", 16'h0000, 1'b0);
    cycles(1);
    checkOutput("latency_edge2", 16'h0000, 1'b0);
    cycles(1);
    checkOutput("latency_edge3", 16'h0001, 1'b0);
    bus.tick_in = 1'b0;
    cycles(3);
    for (int i = 0; i < 11; i++) tickPulse(3, 3);
    checkOutput("twelve_ticks", 16'h0012, 1'b0);
    checkValue("no_wrap_in_12", wraps_seen, 0);

    $display("[TB] up wrap from 9998");
    loadValue(16'h9998);
    checkOutput("load_9998", 16'h9998, 1'b0);
    tickPulse(3, 3);
    checkOutput("up_to_9999", 16'h9999, 1'b0);
    w0 = wraps_seen;
    tickPulse(3, 3);
    checkOutput("up_wrap_0000", 16'h0000, 1'b0);
    checkValue("single_wrap_pulse", wraps_seen - w0, 1);

    $display("[TB] enable gating");
    loadValue(16'h0500);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) tickPulse(3, 3);
    checkOutput("hold_while_disabled", 16'h0500, 1'b0);
    bus.en = 1'b1;
    cycles(4);
    checkOutput("no_replay_on_enable", 16'h0500, 1'b0);
    tickPulse(3, 3);
    checkOutput("advance_by_one", 16'h0501, 1'b0);

    $display("[TB] load beats step, digits clamped");
    bus.tick_in = 1'b1;
    cycles(2);
    bus.load_val = 16'h00AF;
    bus.load     = 1'b1;
    cycles(1);
    bus.load     = 1'b0;
    checkOutput("load_clamp_drop_step", 16'h0099, 1'b0);
    bus.tick_in = 1'b0;
    cycles(4);
    checkOutput("step_stays_dropped", 16'h0099, 1'b0);

`ifdef COUNT_DOWN_EN
    $display("[TB] down count and down wrap");
    loadValue(16'h0000);
    bus.dir = 1'b1;
    w0 = wraps_seen;
    tickPulse(3, 3);
    checkOutput("down_wrap_9999", 16'h9999, 1'b0);
    checkValue("down_wrap_pulse", wraps_seen - w0, 1);
    tickPulse(3, 3);
    checkOutput("down_to_9998", 16'h9998, 1'b0);
    bus.dir = 1'b0;
    loadValue(16'h0099);
`endif

    $display("[TB] reset during pending step");
    bus.tick_in = 1'b1;
    cycles(2);
    rst = 1'b0;
    checkOutput("mid_reset_clear", 16'h0000, 1'b0);
    bus.tick_in = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(6);
    checkOutput("no_step_after_reset", 16'h0000, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) begin
      bus.en  = ($urandom_range(0, 4) != 0);
      bus.dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) loadValue(16'($urandom));
      if ($urandom_range(0, 14) == 0) loadValue(16'h9997);
      tickPulse(int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
    end
    cycles(4);

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
# bcd_counter

Decimal event counter that consumes the divided clock from the counter design's clock divider and advances once per rising edge of it. Runs entirely in the fast system clock domain: the divided clock enters as a plain data input, is synchronized and edge-detected, and the resulting one-cycle step strobe drives a chained multi-digit BCD counter. Supports synchronous load, enable and a wrap flag, and feeds the display stage downstream.

## Interface
- DIGITS, 4, number of BCD decades (1..8)
- clk  input  1  system clock; the only clock in the block
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- tick_in  input  1  divided clock from the clock divider, sampled as data
- en  input  1  count enable; 1 = step strobes advance the count
- dir  input  1  count direction; 0 = up, 1 = down (honoured only with COUNT_DOWN_EN)
- load  input  1  synchronous load request
- load_val  input  4*DIGITS  BCD value to load; digit i at bits [4i+3:4i]
- count  output  4*DIGITS  current BCD count; digit 0 is the least significant
- wrap  output  1  one-cycle pulse when the count wraps (all-9 to 0 up, 0 to all-9 down)

## Operation
- Synchronizer: two flops sync1 → sync2 on tick_in; a third flop prev holds the last sync2.
- step = sync2 & ~prev. step is a 1-clk pulse per tick_in rising edge; falling edges are ignored.
- prev updates every cycle regardless of en, so re-enabling never replays stale edges.
- Priority each cycle: load > (en & step) > hold.
- load: count <= load_val with each digit greater than 9 clamped to 9. wrap = 0. A step in the same cycle is dropped.
- Up step: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. All digits at 9 → all 0 and wrap pulses.
- Down step: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. All digits at 0 → all 9 and wrap pulses.
- Digits are never outside 0..9, whatever the input history.
- en = 0: count holds and wrap stays 0. load still acts.

## Timing
- Reset (rst = 0, asynchronous): sync1, sync2, prev = 0; count = 0; wrap = 0. The block is released on the first clk edge after rst rises.
- If tick_in rises before clk edge k: sync1 = 1 after edge k, sync2 = 1 after edge k+1, step is high in the following cycle, and count updates at edge k+2. Latency is 3 edges from tick_in rising to new count.
- wrap is registered and is high in exactly the same cycle the wrapped count is first visible.
- load takes effect at the next clk edge (1-cycle latency).
- tick_in must stay high and low for at least 2 clk periods each to be counted. The clock divider guarantees this for any FREQ with a nonzero half-period count.
- tick_in already high at reset release is counted as one rising edge. This cannot occur when the clock divider shares the reset, since its output resets to 0.
- Reset asserted mid-count clears everything immediately; no pending step survives reset.

## Configuration
- COUNT_DOWN_EN defined: dir is honoured, including the borrow chain and down-wrap to all-9.
- COUNT_DOWN_EN undefined: dir is ignored and the counter counts up only. No borrow logic is built. Port list is unchanged.

## Structure
- Shared package bcd_pkg:
  - DIGIT_W = 4
  - BCD_MAX = 9
  - clamp function: digit > 9 → 9
- Sub-module bcd_digit: one decade instantiated DIGITS times. Ports: clk, rst, en_in (carry/borrow in), dir, load, load_digit, digit, and carry_out (combinational, true when digit is 9 going up or 0 going down).
- Synchronizer and edge detect live in the top level.
- Top-level wrap = registered AND of all carry_out terms with the step qualifier.

## Test plan
- Reset, then 12 tick_in rising edges with en = 1, dir = 0 → count = 0x0012, wrap never pulses; each update lands 3 clk after its tick_in edge.
- load_val = 0x9998, load pulsed, then 2 ticks up → 0x9999, then 0x0000 with wrap high for exactly 1 clk.
- COUNT_DOWN_EN defined, count = 0x0000, dir = 1, 1 tick → 0x9999 with wrap pulse. 1 more tick → 0x9998.
- en = 0 during 5 ticks, then en = 1, then 1 tick → count advances by exactly 1.
- load asserted in the same cycle as step, with load_val = 0x00AF → count = 0x0099; the step is dropped.
- rst driven low midway between a tick_in edge and its count update → count = 0 and wrap = 0 immediately; no increment after release.
